// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request and instruction-memory write bundle for instr_encoder.
//   slave  modport: encoder side (consumes requests, drives the write port).
//   master modport: loader side (drives requests, observes the write port).
//   op_valid/op_ready  request handshake
//   op_kind, rs, rt, rd, imm  symbolic request fields
//   im_we, im_addr, im_wdata  instruction-memory write port
interface instr_encoder_if #(
  parameter int unsigned pc_width    = 8,
  parameter int unsigned instr_width = 9
);
  logic                   op_valid;
  logic                   op_ready;
  logic [3:0]             op_kind;
  logic [3:0]             rs;
  logic [3:0]             rt;
  logic [3:0]             rd;
  logic [7:0]             imm;
  logic                   im_we;
  logic [pc_width-1:0]    im_addr;
  logic [instr_width-1:0] im_wdata;

  modport slave (
    input  op_valid, op_kind, rs, rt, rd, imm,
    output op_ready, im_we, im_addr, im_wdata
  );

  modport master (
    output op_valid, op_kind, rs, rt, rd, imm,
    input  op_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic operation requests into 9-bit instruction words
// and streams them into instruction memory at consecutive addresses.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   start         pulse: clear address/flags and enter RUN (wins over a request)
//   bus           instr_encoder_if.slave: request handshake + memory write port
//   done          HALT has been written
//   err_illegal   sticky: a request was rejected
//   err_full      sticky: memory overflowed
// Build option: define ENC_FIELD_CHECK_EN to enforce per-operation field ranges;
// otherwise fields are offset and truncated unchecked and only op_kind 15 is rejected.
module instr_encoder #(
  parameter int unsigned pc_width    = 8,
  parameter int unsigned instr_width = 9
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  instr_encoder_if.slave bus,
  output logic           done,
  output logic           err_illegal,
  output logic           err_full
);

  localparam int unsigned WORD_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2,
    ST_FULL   = 2'd3
  } state_e;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_SLT  = 4'd1,
    OP_OR   = 4'd2,
    OP_JR   = 4'd3,
    OP_LW   = 4'd4,
    OP_SW   = 4'd5,
    OP_ADD  = 4'd6,
    OP_ADDI = 4'd7,
    OP_SUB  = 4'd8,
    OP_TR   = 4'd9,
    OP_BEQ  = 4'd10,
    OP_SRL  = 4'd11,
    OP_SRA  = 4'd12,
    OP_SLL  = 4'd13,
    OP_HALT = 4'd14,
    OP_RSVD = 4'd15
  } op_e;

  localparam logic [WORD_W-1:0]   HALT_WORD = 9'b111_0000_11;
  localparam logic [pc_width-1:0] ADDR_LAST = {pc_width{1'b1}};

  op_e                    kind_c;
  logic [WORD_W-1:0]      word_c;
  logic                   range_ok_c;
  logic                   legal_c;
  logic [3:0]             rs_m4_c;
  logic [3:0]             rs_m5_c;
  logic [3:0]             rd_m1_c;
  logic [3:0]             rd_m8_c;

  state_e                 state_q, state_d;
  logic [pc_width-1:0]    addr_q, addr_d;
  logic                   op_ready_q, op_ready_d;
  logic                   im_we_q, im_we_d;
  logic [pc_width-1:0]    im_addr_q, im_addr_d;
  logic [instr_width-1:0] im_wdata_q, im_wdata_d;
  logic                   done_q, done_d;
  logic                   err_illegal_q, err_illegal_d;
  logic                   err_full_q, err_full_d;

  assign kind_c = op_e'(bus.op_kind);

  // Field packing: register numbers are rebased to the decoder's field origin, then truncated.
  always_comb begin : encode
    rs_m4_c = bus.rs - 4'd4;
    rs_m5_c = bus.rs - 4'd5;
    rd_m1_c = bus.rd - 4'd1;
    rd_m8_c = bus.rd - 4'd8;
    word_c  = '0;
    case (kind_c)
      OP_AND, OP_SLT, OP_OR, OP_JR:
        word_c = {3'b000, rs_m4_c[1:0], bus.rt[1:0], bus.op_kind[1:0]};
      OP_LW:   word_c = {3'b001, rs_m4_c[1:0], bus.rd[1:0], 2'b00};
      OP_SW:   word_c = {3'b001, rs_m4_c[1:0], bus.rt[1:0], 2'b01};
      OP_ADD:  word_c = {3'b010, rs_m4_c[1:0], bus.rt[1:0], rd_m8_c[1:0]};
      OP_SUB:  word_c = {3'b100, rs_m4_c[1:0], bus.rt[1:0], rd_m8_c[1:0]};
      OP_ADDI: word_c = {3'b011, rd_m8_c[1:0], bus.rs[1:0], bus.imm[1:0]};
      OP_TR:   word_c = {3'b101, rd_m1_c[2:0], rs_m5_c[2:0]};
      OP_BEQ:  word_c = {3'b110, rs_m4_c[1:0], bus.rt[1:0], 2'b00};
      OP_SRL:  word_c = {3'b111, rs_m4_c[1:0], bus.rt[1:0], 2'b00};
      OP_SRA:  word_c = {3'b111, rs_m4_c[1:0], bus.rt[1:0], 2'b01};
      OP_SLL:  word_c = {3'b111, rs_m4_c[1:0], bus.rt[1:0], 2'b10};
      OP_HALT: word_c = HALT_WORD;
      default: word_c = '0;
    endcase
  end

`ifdef ENC_FIELD_CHECK_EN
  logic rs_std_c;
  logic rt_std_c;

  // Per-operation operand ranges; fields an operation does not use are ignored.
  always_comb begin : range_check
    rs_std_c   = (bus.rs >= 4'd4) && (bus.rs <= 4'd7);
    rt_std_c   = (bus.rt <= 4'd3);
    range_ok_c = 1'b1;
    case (kind_c)
      OP_AND, OP_SLT, OP_OR, OP_JR:
        range_ok_c = rs_std_c && rt_std_c && (bus.rd == 4'd11);
      OP_LW:   range_ok_c = rs_std_c && (bus.rd <= 4'd3);
      OP_SW:   range_ok_c = rs_std_c && rt_std_c;
      OP_ADD, OP_SUB:
        range_ok_c = rs_std_c && rt_std_c && (bus.rd >= 4'd8) && (bus.rd <= 4'd11);
      OP_ADDI:
        range_ok_c = (bus.rd >= 4'd8) && (bus.rd <= 4'd11) && (bus.rs <= 4'd3) &&
                     (bus.imm <= 8'd3);
      OP_TR:
        range_ok_c = (bus.rs >= 4'd5) && (bus.rs <= 4'd12) &&
                     (bus.rd >= 4'd1) && (bus.rd <= 4'd8);
      OP_BEQ:  range_ok_c = rs_std_c && rt_std_c;
      OP_SRL, OP_SRA, OP_SLL:
        range_ok_c = rs_std_c && rt_std_c && (bus.rd == bus.rs);
      default: range_ok_c = 1'b1;
    endcase
  end
`else
  assign range_ok_c = 1'b1;
`endif

  assign legal_c = (kind_c != OP_RSVD) && range_ok_c;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      op_ready_q    <= 1'b0;
      im_we_q       <= 1'b0;
      im_addr_q     <= '0;
      im_wdata_q    <= '0;
      done_q        <= 1'b0;
      err_illegal_q <= 1'b0;
      err_full_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      op_ready_q    <= op_ready_d;
      im_we_q       <= im_we_d;
      im_addr_q     <= im_addr_d;
      im_wdata_q    <= im_wdata_d;
      done_q        <= done_d;
      err_illegal_q <= err_illegal_d;
      err_full_q    <= err_full_d;
    end
  end

  // Next-state and output logic; start overrides any request in the same cycle.
  always_comb begin : fsm
    state_d       = state_q;
    addr_d        = addr_q;
    im_we_d       = 1'b0;
    im_addr_d     = im_addr_q;
    im_wdata_d    = im_wdata_q;
    done_d        = done_q;
    err_illegal_d = err_illegal_q;
    err_full_d    = err_full_q;

    if (start) begin
      state_d       = ST_RUN;
      addr_d        = '0;
      done_d        = 1'b0;
      err_illegal_d = 1'b0;
      err_full_d    = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.op_valid) begin
            if (!legal_c) begin
              err_illegal_d = 1'b1;
            end else begin
              im_we_d    = 1'b1;
              im_addr_d  = addr_q;
              im_wdata_d = instr_width'(word_c);
              if (kind_c == OP_HALT) begin
                state_d = ST_HALTED;
                done_d  = 1'b1;
              end else if (addr_q == ADDR_LAST) begin
                // Last slot written; stop rather than wrap onto address 0.
                state_d    = ST_FULL;
                err_full_d = 1'b1;
              end else begin
                addr_d = addr_q + pc_width'(1);
              end
            end
          end
        end
        default: state_d = state_q;
      endcase
    end

    op_ready_d = (state_d == ST_RUN);
  end

  assign bus.op_ready = op_ready_q;
  assign bus.im_we    = im_we_q;
  assign bus.im_addr  = im_addr_q;
  assign bus.im_wdata = im_wdata_q;
  assign done         = done_q;
  assign err_illegal  = err_illegal_q;
  assign err_full     = err_full_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized and directed bench for instr_encoder, checked against
// an arithmetic model of the encoding rules; a second instance with pc_width=2
// covers the overflow path.
module tb_instr_encoder;

  logic clk;
  logic reset;
  logic start;
  logic start2;
  logic done0, ill0, full0;
  logic done2, ill2, full2;

  int n_tests = 0;
  int n_fail  = 0;

  instr_encoder_if #(.pc_width(8), .instr_width(9)) bus0 ();
  instr_encoder_if #(.pc_width(2), .instr_width(9)) bus2 ();

  instr_encoder #(.pc_width(8), .instr_width(9)) dut0 (
    .clk(clk), .reset(reset), .start(start), .bus(bus0),
    .done(done0), .err_illegal(ill0), .err_full(full0)
  );

  instr_encoder #(.pc_width(2), .instr_width(9)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .bus(bus2),
    .done(done2), .err_illegal(ill2), .err_full(full2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit inr(input int x, input int lo, input int hi);
    return (x >= lo) && (x <= hi);
  endfunction

  // Whether a request is accepted for writing.
  function automatic bit m_legal(input int k, input int rs, input int rt, input int rd,
                                 input int imm);
    if (k == 15) return 1'b0;
`ifdef ENC_FIELD_CHECK_EN
    case (k)
      0, 1, 2, 3: return inr(rs, 4, 7) && inr(rt, 0, 3) && (rd == 11);
      4:          return inr(rs, 4, 7) && inr(rd, 0, 3);
      5, 10:      return inr(rs, 4, 7) && inr(rt, 0, 3);
      6, 8:       return inr(rs, 4, 7) && inr(rt, 0, 3) && inr(rd, 8, 11);
      7:          return inr(rd, 8, 11) && inr(rs, 0, 3) && (imm <= 3);
      9:          return inr(rs, 5, 12) && inr(rd, 1, 8);
      11, 12, 13: return inr(rs, 4, 7) && inr(rt, 0, 3) && (rd == rs);
      default:    return 1'b1;
    endcase
`else
    return 1'b1;
`endif
  endfunction

  // Instruction word as an integer: opcode*64 + field weights.
  function automatic int m_encode(input int k, input int rs, input int rt, input int rd,
                                  input int imm);
    int a4;
    int t2;
    a4 = (rs - 4) & 3;
    t2 = rt & 3;
    case (k)
      0, 1, 2, 3: return a4 * 16 + t2 * 4 + k;
      4:          return 64 + a4 * 16 + (rd & 3) * 4;
      5:          return 64 + a4 * 16 + t2 * 4 + 1;
      6:          return 128 + a4 * 16 + t2 * 4 + ((rd - 8) & 3);
      8:          return 256 + a4 * 16 + t2 * 4 + ((rd - 8) & 3);
      7:          return 192 + ((rd - 8) & 3) * 16 + (rs & 3) * 4 + (imm & 3);
      9:          return 320 + ((rd - 1) & 7) * 8 + ((rs - 5) & 7);
      10:         return 384 + a4 * 16 + t2 * 4;
      11, 12, 13: return 448 + a4 * 16 + t2 * 4 + (k - 11);
      14:         return 451;
      default:    return 0;
    endcase
  endfunction

  // Expected outputs of dut0, updated on every rising edge.
  int m_mode = 0;      // 0 idle, 1 run, 2 halted, 3 full
  int m_addr = 0;
  bit m_live = 1'b0;
  bit e_rst, e_we, e_ready, e_done, e_ill, e_full;
  int e_addr, e_data;

  initial begin : model
    int k, rs, rt, rd, imm;
    forever begin
      @(posedge clk);
      k   = int'(bus0.op_kind);
      rs  = int'(bus0.rs);
      rt  = int'(bus0.rt);
      rd  = int'(bus0.rd);
      imm = int'(bus0.imm);
      e_rst = reset;
      if (reset) begin
        m_mode = 0; m_addr = 0;
        e_we = 0; e_addr = 0; e_data = 0; e_done = 0; e_ill = 0; e_full = 0;
      end else begin
        e_we = 0;
        if (start) begin
          m_mode = 1; m_addr = 0; e_done = 0; e_ill = 0; e_full = 0;
        end else if (m_mode == 1 && bus0.op_valid) begin
          if (!m_legal(k, rs, rt, rd, imm)) begin
            e_ill = 1;
          end else begin
            e_we = 1; e_addr = m_addr; e_data = m_encode(k, rs, rt, rd, imm);
            if (k == 14) begin
              m_mode = 2; e_done = 1;
            end else if (m_addr == 255) begin
              m_mode = 3; e_full = 1;
            end else begin
              m_addr = m_addr + 1;
            end
          end
        end
      end
      e_ready = (m_mode == 1);
      m_live  = 1'b1;
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (m_live) begin
        check("op_ready", 32'(bus0.op_ready), 32'(e_ready));
        check("im_we", 32'(bus0.im_we), 32'(e_we));
        check("done", 32'(done0), 32'(e_done));
        check("err_illegal", 32'(ill0), 32'(e_ill));
        check("err_full", 32'(full0), 32'(e_full));
        if (e_we || e_rst) begin
          check("im_addr", 32'(bus0.im_addr), 32'(e_addr));
          check("im_wdata", 32'(bus0.im_wdata), 32'(e_data));
        end
      end
    end
  end

  task automatic set0(input int k, input int rs, input int rt, input int rd, input int imm);
    bus0.op_kind = 4'(k);
    bus0.rs      = 4'(rs);
    bus0.rt      = 4'(rt);
    bus0.rd      = 4'(rd);
    bus0.imm     = 8'(imm);
  endtask

  task automatic send0(input int k, input int rs, input int rt, input int rd, input int imm);
    set0(k, rs, rt, rd, imm);
    bus0.op_valid = 1'b1;
    @(posedge clk); #1;
    bus0.op_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic expect_write(input string tag, input int addr, input int data);
    check({tag, " we"}, 32'(bus0.im_we), 32'd1);
    check({tag, " addr"}, 32'(bus0.im_addr), 32'(addr));
    check({tag, " data"}, 32'(bus0.im_wdata), 32'(data));
  endtask

  initial begin : driver
    int k, rs, rt, rd, imm;
    reset = 1'b1; start = 1'b0; start2 = 1'b0;
    bus0.op_valid = 1'b0; set0(0, 0, 0, 0, 0);
    bus2.op_valid = 1'b0; bus2.op_kind = 4'd6; bus2.rs = 4'd5; bus2.rt = 4'd2;
    bus2.rd = 4'd9; bus2.imm = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst op_ready", 32'(bus0.op_ready), 32'd0);
    check("rst im_we", 32'(bus0.im_we), 32'd0);
    check("rst im_addr", 32'(bus0.im_addr), 32'd0);
    check("rst im_wdata", 32'(bus0.im_wdata), 32'd0);
    check("rst done", 32'(done0), 32'd0);
    check("rst err_illegal", 32'(ill0), 32'd0);
    check("rst err_full", 32'(full0), 32'd0);
    reset = 1'b0;

    // Pin the model against hand-encoded words.
    check("model ADD", 32'(m_encode(6, 5, 2, 9, 0)), 32'h099);
    check("model ADDI", 32'(m_encode(7, 3, 0, 10, 2)), 32'h0EE);
    check("model TR", 32'(m_encode(9, 7, 0, 3, 0)), 32'h152);
    check("model SLL", 32'(m_encode(13, 6, 1, 6, 0)), 32'h1E6);
    check("model HALT", 32'(m_encode(14, 0, 0, 0, 0)), 32'h1C3);

    pulse_start();
    check("start op_ready", 32'(bus0.op_ready), 32'd1);
    send0(6, 5, 2, 9, 0);   expect_write("ADD", 0, 'h099);
    send0(7, 3, 0, 10, 2);  expect_write("ADDI", 1, 'h0EE);
    send0(9, 7, 0, 3, 0);   expect_write("TR", 2, 'h152);
    send0(14, 0, 0, 0, 0);  expect_write("HALT", 3, 'h1C3);
    check("halt done", 32'(done0), 32'd1);
    check("halt op_ready", 32'(bus0.op_ready), 32'd0);
    send0(6, 5, 2, 9, 0);
    check("halted no write", 32'(bus0.im_we), 32'd0);

    pulse_start();
    check("restart done", 32'(done0), 32'd0);
    check("restart op_ready", 32'(bus0.op_ready), 32'd1);
    send0(13, 6, 1, 6, 0);  expect_write("SLL", 0, 'h1E6);
    send0(0, 4, 1, 9, 0);
`ifdef ENC_FIELD_CHECK_EN
    check("AND rd9 we", 32'(bus0.im_we), 32'd0);
    check("AND rd9 err_illegal", 32'(ill0), 32'd1);
    send0(6, 5, 2, 9, 0);   expect_write("after illegal", 1, 'h099);
`else
    expect_write("AND rd9", 1, 'h004);
    check("AND rd9 err_illegal", 32'(ill0), 32'd0);
    send0(6, 5, 2, 9, 0);   expect_write("after AND", 2, 'h099);
`endif
    send0(15, 5, 2, 9, 0);
    check("rsvd we", 32'(bus0.im_we), 32'd0);
    check("rsvd err_illegal", 32'(ill0), 32'd1);

    // Reset together with a request: nothing is written.
    set0(6, 5, 2, 9, 0);
    bus0.op_valid = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    bus0.op_valid = 1'b0; reset = 1'b0;
    check("rst+req we", 32'(bus0.im_we), 32'd0);
    check("rst+req op_ready", 32'(bus0.op_ready), 32'd0);
    check("rst+req err_illegal", 32'(ill0), 32'd0);

    // Reset right after an accepted request returns every output to its reset value.
    pulse_start();
    send0(7, 3, 0, 10, 2);  expect_write("pre-reset", 0, 'h0EE);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("post-reset we", 32'(bus0.im_we), 32'd0);
    check("post-reset addr", 32'(bus0.im_addr), 32'd0);
    check("post-reset data", 32'(bus0.im_wdata), 32'd0);
    check("post-reset op_ready", 32'(bus0.op_ready), 32'd0);
    send0(6, 5, 2, 9, 0);
    check("idle no write", 32'(bus0.im_we), 32'd0);

    // Overflow on the 4-entry instance, requests back to back.
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    bus2.op_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("full we", 32'(bus2.im_we), 32'd1);
      check("full addr", 32'(bus2.im_addr), 32'(i));
      check("full data", 32'(bus2.im_wdata), 32'h099);
      check("full err_full", 32'(full2), (i == 3) ? 32'd1 : 32'd0);
    end
    check("full op_ready", 32'(bus2.op_ready), 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      check("full no write", 32'(bus2.im_we), 32'd0);
    end
    bus2.op_valid = 1'b0;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    check("full cleared", 32'(full2), 32'd0);
    check("full restart ready", 32'(bus2.op_ready), 32'd1);

    // Randomized traffic with occasional start and reset.
    pulse_start();
    for (int i = 0; i < 3000; i++) begin
      k   = int'($urandom_range(0, 15));
      rs  = int'($urandom_range(0, 15));
      rt  = int'($urandom_range(0, 15));
      rd  = int'($urandom_range(0, 15));
      imm = int'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        rs = int'($urandom_range(4, 7));
        rt = int'($urandom_range(0, 3));
        case (k)
          0, 1, 2, 3: rd = 11;
          4:          rd = int'($urandom_range(0, 3));
          6, 8:       rd = int'($urandom_range(8, 11));
          7: begin
            rd = int'($urandom_range(8, 11)); rs = int'($urandom_range(0, 3));
            imm = int'($urandom_range(0, 3));
          end
          9: begin
            rs = int'($urandom_range(5, 12)); rd = int'($urandom_range(1, 8));
          end
          11, 12, 13: rd = rs;
          default: ;
        endcase
      end
      set0(k, rs, rt, rd, imm);
      bus0.op_valid = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 24) == 0);
      reset = ($urandom_range(0, 399) == 0);
      @(posedge clk); #1;
    end
    bus0.op_valid = 1'b0; start = 1'b0; reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
